// File: rtl/procb_rd_sched_pkg.sv
// procb_rd_sched_pkg: shared types and helpers for the procb read scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Fallback values for the shared sha512.vh definitions, used when that header
// has not already been pulled into the compilation unit.
`ifndef PROCB_D_WIDTH
`define PROCB_D_WIDTH 72
`endif
`ifndef PROCB_FIN_BIT
`define PROCB_FIN_BIT 64
`endif
`ifndef MSB
`define MSB(x) (((x) < 2) ? 0 : ($clog2((x) + 1) - 1))
`endif

package procb_rd_sched_pkg;

  // Buffer read strobes, always produced together by the scheduler FSM.
  typedef struct packed {
    logic rd_en;
    logic lookup_en;
    logic rd_rst;
  } rd_strb_t;

  // Modular add for round-robin offsets; base < n and off <= n are assumed.
  function automatic int wrap_idx(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant over a request vector, searching upward from last-served + 1.
// Latency: purely combinational, grant valid in the same cycle as the requests.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arbiter
  import procb_rd_sched_pkg::*;
#(
  parameter int N_REQ = 16,
  parameter int IDX_W = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [IDX_W-1:0] o_gnt,
  output logic             o_gnt_vld
);

  logic [IDX_W-1:0] w_sel;

  // Walk offsets from farthest to nearest so the closest requester above last-served wins;
  // offset N_REQ lands on last-served itself, which therefore has the lowest priority.
  always_comb begin
    o_gnt     = i_last;
    o_gnt_vld = 1'b0;
    w_sel     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_sel = IDX_W'(wrap_idx(int'(i_last), k, N_REQ));
      if (i_req[w_sel]) begin
        o_gnt     = w_sel;
        o_gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/procb_rd_sched.sv
// procb_rd_sched: picks a ready thread round-robin and streams its procb records to the consumer.
// Latency: 3 cycles from pick to first possible rec_valid; records pass through combinationally.
// Backpressure: cons_ready low or lookup_empty high stalls in XFER with all read strobes low.
// Optional feature: define PROCB_SCHED_TIMEOUT_EN for the stall timeout and sticky err flag.
module procb_rd_sched
  import procb_rd_sched_pkg::*;
#(
  parameter int N_THREADS     = 16,
  parameter int N_THREADS_MSB = `MSB(N_THREADS-1)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_THREADS-1:0]      thread_rdy,
  input  logic                      lookup_empty,
  input  logic [`PROCB_D_WIDTH-1:0] procb_dout,
  input  logic                      cons_ready,
  input  logic                      abort,
  output logic [N_THREADS_MSB:0]    rd_thread_num,
  output logic                      rd_en,
  output logic                      rd_rst,
  output logic                      lookup_en,
  output logic                      rec_valid,
  output logic                      thread_done,
  output logic [N_THREADS_MSB:0]    done_thread_num,
  output logic                      err
);

  localparam int TW = N_THREADS_MSB + 1;
  localparam logic [TW-1:0] LAST_RST = TW'(N_THREADS - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE1 = 3'd1;
  localparam logic [2:0] ST_SETTLE2 = 3'd2;
  localparam logic [2:0] ST_XFER    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    SETTLE1 = ST_SETTLE1,
    SETTLE2 = ST_SETTLE2,
    XFER    = ST_XFER,
    DONE    = ST_DONE
  } state_t;

  state_t               r_state;
  state_t               w_nxt_state;
  logic [TW-1:0]        r_thread;
  logic [TW-1:0]        r_last;
  logic [TW-1:0]        r_done_num;
  logic [N_THREADS-1:0] r_armed;

  logic [N_THREADS-1:0] w_elig;
  logic [TW-1:0]        w_pick;
  logic                 w_pick_vld;
  logic                 w_fin;
  logic                 w_active;
  logic                 w_timeout;
  logic                 w_abort;
  logic                 w_rec_vld;
  logic                 w_accept;
  logic                 w_enter_done;
  rd_strb_t             w_strb;
  logic                 w_unused_dout;

  // A thread that just finished stays out of the draw until its ready bit drops.
  assign w_elig = thread_rdy & r_armed;

  rr_arbiter #(
    .N_REQ (N_THREADS),
    .IDX_W (TW)
  ) u_rr_arbiter (
    .i_req     (w_elig),
    .i_last    (r_last),
    .o_gnt     (w_pick),
    .o_gnt_vld (w_pick_vld)
  );

  // Only the fin bit steers the FSM; the payload is passed through untouched.
  assign w_fin         = procb_dout[`PROCB_FIN_BIT];
  assign w_unused_dout = ^procb_dout;

  // Abort is meaningful only while a thread is being read; in DONE the thread is already finished.
  assign w_active  = (r_state == SETTLE1) || (r_state == SETTLE2) || (r_state == XFER);
  assign w_abort   = w_active & (abort | w_timeout);
  assign w_rec_vld = (r_state == XFER) & ~lookup_empty;
  assign w_accept  = w_rec_vld & cons_ready & ~w_abort;

  // Next-state and read strobes; abort overrides whatever XFER would have done.
  always_comb begin
    w_nxt_state = r_state;
    w_strb      = '0;
    case (r_state)
      IDLE:    if (w_pick_vld) w_nxt_state = SETTLE1;
      SETTLE1: w_nxt_state = SETTLE2;
      SETTLE2: w_nxt_state = XFER;
      XFER: begin
        if (w_accept) begin
          w_strb.rd_en     = 1'b1;
          w_strb.lookup_en = 1'b1;
          if (w_fin) begin
            w_strb.rd_rst = 1'b1;
            w_nxt_state   = DONE;
          end
        end
      end
      DONE:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
    if (w_abort) begin
      w_strb.rd_en     = 1'b1;
      w_strb.lookup_en = 1'b0;
      w_strb.rd_rst    = 1'b1;
      w_nxt_state      = DONE;
    end
  end

  assign w_enter_done = (w_nxt_state == DONE) && (r_state != DONE);

  // Strobes are masked during reset so an abandoned transfer never flushes or pops the buffer.
  assign rd_en           = w_strb.rd_en & ~RST;
  assign lookup_en       = w_strb.lookup_en & ~RST;
  assign rd_rst          = w_strb.rd_rst & ~RST;
  assign rec_valid       = w_rec_vld & ~RST;
  assign thread_done     = (r_state == DONE) & ~RST;
  assign rd_thread_num   = r_thread;
  assign done_thread_num = r_done_num;

  // State, selected thread and last-served pointer; the thread is latched only when leaving IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_thread   <= '0;
      r_last     <= LAST_RST;
      r_done_num <= '0;
    end else begin
      r_state <= w_nxt_state;
      if ((r_state == IDLE) && w_pick_vld) begin
        r_thread <= w_pick;
        r_last   <= w_pick;
      end
      if (w_enter_done) r_done_num <= r_thread;
    end
  end

  // Disarm the served thread on entering DONE; re-arm any thread whose ready bit is seen low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_armed <= '1;
    end else begin
      for (int i = 0; i < N_THREADS; i++) begin
        if (w_enter_done && (r_thread == TW'(i))) r_armed[i] <= 1'b0;
        else if (!thread_rdy[i])                  r_armed[i] <= 1'b1;
      end
    end
  end

`ifdef PROCB_SCHED_TIMEOUT_EN
  localparam int STALL_W = 8;
  localparam logic [STALL_W-1:0] STALL_LIMIT = 8'd255;

  logic [STALL_W-1:0] r_stall;
  logic               r_err;

  // Fires on the 255th consecutive empty XFER cycle, counting the current one.
  assign w_timeout = (r_state == XFER) & lookup_empty & (r_stall == (STALL_LIMIT - STALL_W'(1)));
  assign err       = r_err;

  // Stall counter runs only across uninterrupted empty XFER cycles; err is sticky until reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall <= '0;
      r_err   <= 1'b0;
    end else begin
      if ((r_state == XFER) && lookup_empty && (w_nxt_state == XFER)) r_stall <= r_stall + STALL_W'(1);
      else                                                          r_stall <= '0;
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_procb_rd_sched.sv
// tb_procb_rd_sched: directed checks of thread selection, record streaming, abort and re-arm.
// A small per-thread buffer model answers lookup_empty/procb_dout for the selected thread.
`ifndef PROCB_D_WIDTH
`define PROCB_D_WIDTH 72
`endif
`ifndef PROCB_FIN_BIT
`define PROCB_FIN_BIT 64
`endif

module tb_procb_rd_sched;
  localparam int NT = 16;
  localparam int DW = `PROCB_D_WIDTH;
  localparam int FB = `PROCB_FIN_BIT;

  logic          CLK = 1'b0;
  logic          RST;
  logic [NT-1:0] thread_rdy;
  logic          lookup_empty;
  logic [DW-1:0] procb_dout;
  logic          cons_ready;
  logic          abort;
  logic [3:0]    rd_thread_num;
  logic          rd_en, rd_rst, lookup_en, rec_valid, thread_done, err;
  logic [3:0]    done_thread_num;

  always #5 CLK = ~CLK;

  procb_rd_sched #(.N_THREADS(NT)) dut (
    .CLK(CLK), .RST(RST), .thread_rdy(thread_rdy), .lookup_empty(lookup_empty),
    .procb_dout(procb_dout), .cons_ready(cons_ready), .abort(abort),
    .rd_thread_num(rd_thread_num), .rd_en(rd_en), .rd_rst(rd_rst), .lookup_en(lookup_en),
    .rec_valid(rec_valid), .thread_done(thread_done), .done_thread_num(done_thread_num), .err(err)
  );

  // Buffer model: per-thread record store, write pointer from stimulus, read pointer from DUT strobes.
  logic [DW-1:0] mem [NT][16];
  int wptr [NT];
  int rptr [NT];
  assign lookup_empty = (rptr[rd_thread_num] == wptr[rd_thread_num]);
  assign procb_dout   = mem[rd_thread_num][4'(rptr[rd_thread_num])];

  int n_rden = 0, n_rst = 0, n_done = 0, acc_n = 0;
  logic [15:0] acc_log [64];

  always @(posedge CLK) begin
    if (!RST) begin
      if (rd_en && lookup_en) begin
        rptr[rd_thread_num] <= rptr[rd_thread_num] + 1;
        acc_log[acc_n]      <= procb_dout[15:0];
        acc_n               <= acc_n + 1;
      end
      if (rd_rst) rptr[rd_thread_num] <= wptr[rd_thread_num];
      if (rd_en) n_rden <= n_rden + 1;
      if (rd_rst) n_rst <= n_rst + 1;
      if (thread_done) n_done <= n_done + 1;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #2;
  endtask

  task automatic push(input int t, input int k, input bit fin);
    logic [DW-1:0] r;
    r        = '0;
    r[15:8]  = 8'(t);
    r[7:0]   = 8'(k);
    r[FB]    = fin;
    mem[t][4'(wptr[t])] = r;
    wptr[t]  = wptr[t] + 1;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int c;
    c = 0;
    while (!thread_done && c < max_cyc) begin
      nxt();
      c++;
    end
    chk({tag, "_seen"}, 32'(thread_done), 32'd1);
  endtask

  int b_rden, b_rst, b_acc, b_done;

  initial begin
    RST = 1'b1; thread_rdy = '0; cons_ready = 1'b0; abort = 1'b0;
    repeat (3) nxt();
    RST = 1'b0;
    nxt();
    chk("rst_thr", 32'(rd_thread_num), 32'd0);
    chk("rst_rden", 32'(rd_en), 32'd0);
    chk("rst_rdrst", 32'(rd_rst), 32'd0);
    chk("rst_lken", 32'(lookup_en), 32'd0);
    chk("rst_rv", 32'(rec_valid), 32'd0);
    chk("rst_done", 32'(thread_done), 32'd0);
    chk("rst_dnum", 32'(done_thread_num), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // abort in IDLE is ignored
    abort = 1'b1; #1;
    chk("idle_abort_rden", 32'(rd_en), 32'd0);
    chk("idle_abort_rdrst", 32'(rd_rst), 32'd0);
    nxt(); abort = 1'b0; #1;
    chk("idle_abort_done", 32'(thread_done), 32'd0);

    // Scenario 1: thread 2, three records, fin on the third
    push(2, 0, 0); push(2, 1, 0); push(2, 2, 1);
    cons_ready = 1'b1; b_rden = n_rden; b_rst = n_rst; b_acc = acc_n;
    thread_rdy = 16'h0004; #1;
    chk("s1_pick_rv", 32'(rec_valid), 32'd0);
    nxt(); thread_rdy = '0; #1;
    chk("s1_thr", 32'(rd_thread_num), 32'd2);
    chk("s1_s1_rv", 32'(rec_valid), 32'd0);
    nxt();
    chk("s1_s2_rv", 32'(rec_valid), 32'd0);
    nxt();
    chk("s1_c3_rv", 32'(rec_valid), 32'd1);
    chk("s1_c3_rden", 32'(rd_en), 32'd1);
    chk("s1_c3_lken", 32'(lookup_en), 32'd1);
    chk("s1_c3_rdrst", 32'(rd_rst), 32'd0);
    nxt();
    nxt();
    chk("s1_fin_rdrst", 32'(rd_rst), 32'd1);
    chk("s1_fin_rden", 32'(rd_en), 32'd1);
    nxt();
    chk("s1_done", 32'(thread_done), 32'd1);
    chk("s1_dnum", 32'(done_thread_num), 32'd2);
    chk("s1_done_rden", 32'(rd_en), 32'd0);
    nxt();
    chk("s1_done_pulse", 32'(thread_done), 32'd0);
    chk("s1_rden_cnt", 32'(n_rden - b_rden), 32'd3);
    chk("s1_rdrst_cnt", 32'(n_rst - b_rst), 32'd1);
    chk("s1_rec0", 32'(acc_log[b_acc]), 32'h0200);
    chk("s1_rec1", 32'(acc_log[b_acc + 1]), 32'h0201);
    chk("s1_rec2", 32'(acc_log[b_acc + 2]), 32'h0202);

    // Scenario 2: last-served=15 after reset, threads 0 and 15 ready
    RST = 1'b1; nxt(); nxt(); RST = 1'b0; nxt();
    push(0, 0, 1); push(15, 0, 0); push(15, 1, 1);
    thread_rdy = 16'h8001;
    nxt();
    chk("s2_first", 32'(rd_thread_num), 32'd0);
    wait_done("s2_t0", 20);
    chk("s2_t0_dnum", 32'(done_thread_num), 32'd0);
    nxt(); nxt();
    chk("s2_second", 32'(rd_thread_num), 32'd15);
    wait_done("s2_t15", 20);
    chk("s2_t15_dnum", 32'(done_thread_num), 32'd15);
    thread_rdy = '0;
    nxt();
    push(0, 1, 1);
    thread_rdy = 16'h8001;
    nxt();
    chk("s2_wrap", 32'(rd_thread_num), 32'd0);
    wait_done("s2_wrap", 20);
    thread_rdy = '0;
    nxt();

    // Scenario 3: consumer stalls for 4 XFER cycles
    push(5, 0, 0); push(5, 1, 0); push(5, 2, 1);
    cons_ready = 1'b0; b_rden = n_rden; b_acc = acc_n;
    thread_rdy = 16'h0020;
    nxt(); thread_rdy = '0;
    nxt(); nxt();
    for (int i = 0; i < 4; i++) begin
      chk("s3_stall_rv", 32'(rec_valid), 32'd1);
      chk("s3_stall_rden", 32'(rd_en), 32'd0);
      chk("s3_stall_lken", 32'(lookup_en), 32'd0);
      nxt();
    end
    cons_ready = 1'b1;
    wait_done("s3", 20);
    chk("s3_rden_cnt", 32'(n_rden - b_rden), 32'd3);
    chk("s3_rec0", 32'(acc_log[b_acc]), 32'h0500);
    chk("s3_rec1", 32'(acc_log[b_acc + 1]), 32'h0501);
    chk("s3_rec2", 32'(acc_log[b_acc + 2]), 32'h0502);
    nxt();

    // Scenario 4: abort on the second record, racing an acceptable record
    push(7, 0, 0); push(7, 1, 0); push(7, 2, 1);
    b_acc = acc_n;
    thread_rdy = 16'h0080;
    nxt(); thread_rdy = '0;
    nxt(); nxt();
    nxt(); abort = 1'b1; #1;
    chk("s4_abort_rden", 32'(rd_en), 32'd1);
    chk("s4_abort_rdrst", 32'(rd_rst), 32'd1);
    chk("s4_abort_lken", 32'(lookup_en), 32'd0);
    chk("s4_abort_done", 32'(thread_done), 32'd0);
    nxt(); abort = 1'b0; #1;
    chk("s4_done", 32'(thread_done), 32'd1);
    chk("s4_dnum", 32'(done_thread_num), 32'd7);
    chk("s4_acc_cnt", 32'(acc_n - b_acc), 32'd1);
    chk("s4_rec0", 32'(acc_log[b_acc]), 32'h0700);
    nxt();

    // Scenario 5: thread_rdy held high after done must not reselect
    push(9, 0, 1);
    thread_rdy = 16'h0200;
    wait_done("s5_first", 20);
    chk("s5_dnum", 32'(done_thread_num), 32'd9);
    push(9, 1, 1);
    b_rden = n_rden;
    repeat (8) nxt();
    chk("s5_no_resel", 32'(n_rden - b_rden), 32'd0);
    chk("s5_no_rv", 32'(rec_valid), 32'd0);
    thread_rdy = '0;
    nxt();
    thread_rdy = 16'h0200;
    wait_done("s5_resel", 20);
    chk("s5_resel_dnum", 32'(done_thread_num), 32'd9);
    chk("s5_resel_rden", 32'(n_rden - b_rden), 32'd1);
    thread_rdy = '0;
    nxt();

    // Reset mid-transfer: no strobes, no thread_done
    push(3, 0, 0); push(3, 1, 1);
    cons_ready = 1'b0;
    thread_rdy = 16'h0008;
    nxt(); thread_rdy = '0;
    nxt(); nxt();
    chk("rm_xfer_rv", 32'(rec_valid), 32'd1);
    b_done = n_done; b_rst = n_rst;
    RST = 1'b1; cons_ready = 1'b1; #1;
    chk("rm_rden", 32'(rd_en), 32'd0);
    chk("rm_rdrst", 32'(rd_rst), 32'd0);
    nxt(); RST = 1'b0;
    nxt(); nxt();
    chk("rm_no_done", 32'(n_done - b_done), 32'd0);
    chk("rm_no_rdrst", 32'(n_rst - b_rst), 32'd0);
    chk("rm_thr", 32'(rd_thread_num), 32'd0);

`ifdef PROCB_SCHED_TIMEOUT_EN
    // Scenario 6: empty thread stalls until the timeout fires
    begin
      int c;
      thread_rdy = 16'h0800;
      nxt(); thread_rdy = '0;
      nxt(); nxt();
      c = 1;
      while (!rd_rst && c < 300) begin
        nxt();
        c++;
      end
      chk("to_cycle", 32'(c), 32'd255);
      nxt();
      chk("to_done", 32'(thread_done), 32'd1);
      chk("to_err", 32'(err), 32'd1);
      RST = 1'b1; nxt(); RST = 1'b0; nxt();
      chk("to_err_clr", 32'(err), 32'd0);
    end
`else
    chk("no_to_err", 32'(err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_chk, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/procb_rd_sched.md
PROCB_RD_SCHED -- requirements
Module: procb_rd_sched

Interface
REQ-001 SHALL have parameter N_THREADS, default 16: number of threads sharing the procb buffer.
REQ-002 SHALL have parameter N_THREADS_MSB, default `MSB(N_THREADS-1): thread-number MSB.
REQ-003 SHALL have CLK, input, 1: sole clock; all logic on posedge.
REQ-004 SHALL have RST, input, 1: synchronous, active-high reset.
REQ-005 SHALL have thread_rdy, input, N_THREADS: bit i high means thread i holds a complete procb sequence.
REQ-006 SHALL have lookup_empty, input, 1: from the procb buffer, for the current read thread.
REQ-007 SHALL have procb_dout, input, `PROCB_D_WIDTH: record from the procb buffer (first-word fall-through).
REQ-008 SHALL have cons_ready, input, 1: consumer accepts a record this cycle.
REQ-009 SHALL have abort, input, 1: terminate the current thread's transfer.
REQ-010 SHALL have rd_thread_num, output, N_THREADS_MSB+1: thread selected for reading.
REQ-011 SHALL have rd_en, rd_rst and lookup_en, each output, 1: buffer read controls.
REQ-012 SHALL have rec_valid, output, 1: procb_dout is a valid record for the consumer.
REQ-013 SHALL have thread_done, output, 1, and done_thread_num, output, N_THREADS_MSB+1: one-cycle completion pulse and its thread.
REQ-014 SHALL have err, output, 1: sticky error flag.

Function
REQ-015 SHALL implement the states IDLE, SETTLE1, SETTLE2, XFER and DONE.
REQ-016 IDLE: when any eligible thread_rdy bit is set, SHALL pick the thread by round-robin, starting one above the last-served thread and wrapping N_THREADS-1 to 0.
REQ-017 SHALL drive rd_thread_num to the picked thread on the cycle it leaves IDLE, and SHALL hold it stable until the next IDLE.
REQ-018 SHALL pass through SETTLE1 and SETTLE2 unconditionally, covering the 2-cycle read latency after a thread change, then enter XFER.
REQ-019 XFER: rec_valid SHALL equal ~lookup_empty.
REQ-020 XFER: on rec_valid & cons_ready, rd_en and lookup_en SHALL both pulse in the same cycle.
REQ-021 When that accepted record has bit `PROCB_FIN_BIT set, rd_rst SHALL also pulse and the next state SHALL be DONE.
REQ-022 XFER with lookup_empty high and no fin bit seen: SHALL stall in XFER with all read strobes low.
REQ-023 abort while not in IDLE SHALL pulse rd_en & rd_rst, accept no record that cycle, and go to DONE; abort in IDLE SHALL be ignored.
REQ-024 If abort and an accepted record occur in the same cycle, abort SHALL win.
REQ-025 DONE: thread_done=1 and done_thread_num=served thread for exactly one cycle, then IDLE.
REQ-026 On entering DONE, the served thread SHALL become ineligible; it SHALL be re-armed only after its thread_rdy is sampled low.
REQ-027 rd_en, lookup_en and rd_rst SHALL never be asserted outside XFER, except the abort pulse in REQ-023.
REQ-028 Selection to first possible rec_valid SHALL take 3 cycles (IDLE->SETTLE1->SETTLE2->XFER).
REQ-029 thread_rdy changes outside IDLE SHALL not affect the current transfer.

Reset
REQ-030 RST SHALL force state IDLE; rd_thread_num=0; rd_en, rd_rst, lookup_en, rec_valid, thread_done and err=0; done_thread_num=0; last-served=N_THREADS-1; all threads armed.
REQ-031 RST mid-transfer SHALL abandon the thread without a thread_done pulse or rd_rst.

Configuration
REQ-032 Macro PROCB_SCHED_TIMEOUT_EN, when defined: an 8-bit stall counter SHALL count consecutive XFER cycles with lookup_empty high.
REQ-033 With PROCB_SCHED_TIMEOUT_EN defined, reaching 255 SHALL set err and perform the abort action of REQ-023; the counter SHALL clear on any accepted record or state change.
REQ-034 Without PROCB_SCHED_TIMEOUT_EN: no counter SHALL exist, err SHALL be constant 0, and stalls SHALL last indefinitely.

Structure
REQ-035 `PROCB_D_WIDTH, `PROCB_FIN_BIT and `MSB SHALL come from the shared sha512.vh header; state encodings SHALL be local localparams.
REQ-036 Round-robin selection SHALL be one sub-module, rr_arbiter (inputs: request vector, last-served; output: grant number plus valid).

Verification
REQ-037 Scenario 1: thread_rdy=16'h0004, 3 records with fin on the 3rd, cons_ready=1 -> rd_thread_num=2; rec_valid at cycle 3 after pick; 3 rd_en pulses; rd_rst with the 3rd; thread_done with done_thread_num=2.
REQ-038 Scenario 2: thread_rdy=16'h8001, last-served=15 -> thread 0 served first, then 15; 15 to 0 wrap checked.
REQ-039 Scenario 3: cons_ready low 4 cycles during XFER -> no rd_en/lookup_en pulses during the stall; record order intact.
REQ-040 Scenario 4: abort on 2nd record -> rd_en & rd_rst pulse, no record accepted, thread_done next cycle.
REQ-041 Scenario 5: thread_rdy held high after done -> thread not reselected until thread_rdy is low 1 cycle then high.
REQ-042 Scenario 6 (TIMEOUT_EN): lookup_empty stuck high 255 cycles in XFER -> err=1, rd_rst pulse, IDLE; RST clears err.
